// File: rtl/cache_types_pkg.sv
// Shared types and constants for the 2-way set-associative cache controller.
package cache_types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_t;

  localparam logic DSEL_CPU    = 1'b0;
  localparam logic DSEL_PMEM   = 1'b1;
  localparam logic ASEL_CPU    = 1'b0;
  localparam logic ASEL_VICTIM = 1'b1;

  localparam int NUM_WAYS = 2;

endpackage

// File: rtl/cache_victim_sel.sv
// Picks the way to replace on a miss: the lowest invalid way, otherwise the LRU way.
module cache_victim_sel
  import cache_types_pkg::*;
(
  input  logic [NUM_WAYS-1:0] valid_way,
  input  logic                lru_way,
  output logic                victim
);

  always_comb begin
    victim = lru_way;
    if (!valid_way[0]) begin
      victim = 1'b0;
    end else if (!valid_way[1]) begin
      victim = 1'b1;
    end
  end

endmodule

// File: rtl/cache_control.sv
// Cache controller FSM: serves hits in IDLE, writes back dirty victims, then fills the line.
module cache_control
  import cache_types_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic [1:0]           hit_way,
  input  logic [1:0]           valid_way,
  input  logic [1:0]           dirty_way,
  input  logic                 lru_way,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  output logic [1:0]           load_data,
  output logic [1:0]           load_tag,
  output logic [1:0]           load_valid,
  output logic [1:0]           load_dirty,
  output logic                 dirty_in,
  output logic                 load_lru,
  output logic                 lru_in,
  output logic                 data_sel,
  output logic                 addr_sel,
  output logic                 way_sel,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  state_t state, next_state;
  logic   victim_q;
  logic   victim_new;
  logic   req;
  logic   hit;
  logic   hit_w;
  logic   hit_evt;
  logic   miss_evt;

  assign req   = mem_read | mem_write;
  assign hit   = |hit_way;
  // Way 0 wins if the datapath ever reports both ways matching.
  assign hit_w = ~hit_way[0];

  cache_victim_sel u_victim_sel (
    .valid_way (valid_way),
    .lru_way   (lru_way),
    .victim    (victim_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      victim_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      if (miss_evt) begin
        victim_q   <= victim_new;
        miss_count <= miss_count + CNT_WIDTH'(1);
      end
      if (hit_evt) begin
        hit_count <= hit_count + CNT_WIDTH'(1);
      end
    end
  end

  // Outputs are forced low while reset is held, whatever the inputs show.
  always_comb begin
    next_state = state;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    load_data  = 2'b00;
    load_tag   = 2'b00;
    load_valid = 2'b00;
    load_dirty = 2'b00;
    dirty_in   = 1'b0;
    load_lru   = 1'b0;
    lru_in     = 1'b0;
    data_sel   = DSEL_CPU;
    addr_sel   = ASEL_CPU;
    way_sel    = 1'b0;
    hit_evt    = 1'b0;
    miss_evt   = 1'b0;

    if (rst_n) begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            mem_resp = 1'b1;
            way_sel  = hit_w;
            load_lru = 1'b1;
            lru_in   = ~hit_w;
            hit_evt  = 1'b1;
            if (mem_write) begin
              load_data[hit_w]  = 1'b1;
              load_dirty[hit_w] = 1'b1;
              dirty_in          = 1'b1;
              data_sel          = DSEL_CPU;
            end
          end else if (req) begin
            miss_evt = 1'b1;
            if (valid_way[victim_new] && dirty_way[victim_new]) begin
              next_state = WRITEBACK;
            end else begin
              next_state = FILL;
            end
          end
        end

        WRITEBACK: begin
          pmem_write = 1'b1;
          addr_sel   = ASEL_VICTIM;
          way_sel    = victim_q;
          if (pmem_resp) begin
            next_state = FILL;
          end
        end

        FILL: begin
          pmem_read = 1'b1;
          addr_sel  = ASEL_CPU;
          if (pmem_resp) begin
            load_data[victim_q]  = 1'b1;
            load_tag[victim_q]   = 1'b1;
            load_valid[victim_q] = 1'b1;
            load_dirty[victim_q] = 1'b1;
            dirty_in             = 1'b0;
            data_sel             = DSEL_PMEM;
            next_state           = IDLE;
          end
        end

        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: directed stimulus pushes expected responses, a monitor checks them.
module tb_cache_control;

  localparam int CNT_WIDTH = 16;

  logic                 clk;
  logic                 rst_n;
  logic                 mem_read;
  logic                 mem_write;
  logic                 mem_resp;
  logic [1:0]           hit_way;
  logic [1:0]           valid_way;
  logic [1:0]           dirty_way;
  logic                 lru_way;
  logic                 pmem_read;
  logic                 pmem_write;
  logic                 pmem_resp;
  logic [1:0]           load_data;
  logic [1:0]           load_tag;
  logic [1:0]           load_valid;
  logic [1:0]           load_dirty;
  logic                 dirty_in;
  logic                 load_lru;
  logic                 lru_in;
  logic                 data_sel;
  logic                 addr_sel;
  logic                 way_sel;
  logic [CNT_WIDTH-1:0] hit_count;
  logic [CNT_WIDTH-1:0] miss_count;

  int checks   = 0;
  int failures = 0;
  logic [16:0] exp_q[$];

  cache_control #(.CNT_WIDTH(CNT_WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_resp   (mem_resp),
    .hit_way    (hit_way),
    .valid_way  (valid_way),
    .dirty_way  (dirty_way),
    .lru_way    (lru_way),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_resp  (pmem_resp),
    .load_data  (load_data),
    .load_tag   (load_tag),
    .load_valid (load_valid),
    .load_dirty (load_dirty),
    .dirty_in   (dirty_in),
    .load_lru   (load_lru),
    .lru_in     (lru_in),
    .data_sel   (data_sel),
    .addr_sel   (addr_sel),
    .way_sel    (way_sel),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed response: resp, load_data, load_tag, load_valid, load_dirty, dirty_in,
  // load_lru, lru_in, data_sel, addr_sel, way_sel, pmem_read, pmem_write.
  function automatic logic [16:0] ev(logic resp, logic [1:0] ld, logic [1:0] lt,
                                     logic [1:0] lv, logic [1:0] lk, logic din,
                                     logic llru, logic lin, logic dsel, logic asel,
                                     logic wsel, logic pr, logic pw);
    return {resp, ld, lt, lv, lk, din, llru, lin, dsel, asel, wsel, pr, pw};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {mem_resp, load_data, load_tag, load_valid, load_dirty, dirty_in,
            load_lru, lru_in, data_sel, addr_sel, way_sel, pmem_read, pmem_write};
  endfunction

  // Monitor: every cycle with a response or an array load must match the next queued entry.
  always @(negedge clk) begin
    if (rst_n && (mem_resp || load_lru || (|load_data) || (|load_tag) ||
                  (|load_valid) || (|load_dirty))) begin
      logic [16:0] want;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_event: got %h want none", dut_vec());
      end else begin
        want = exp_q.pop_front();
        if (dut_vec() !== want) begin
          failures++;
          $display("[TB] FAIL event: got %h want %h", dut_vec(), want);
        end
      end
    end
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] hit,
                               input logic [1:0] valid, input logic [1:0] dirty,
                               input logic lru, input logic presp);
    mem_read  = rd;
    mem_write = wr;
    hit_way   = hit;
    valid_way = valid;
    dirty_way = dirty;
    lru_way   = lru;
    pmem_resp = presp;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0);
    #12;
    checkOutput("reset_outputs", 32'(dut_vec()), 32'h0);
    checkOutput("reset_hit_count", 32'(hit_count), 32'h0);
    checkOutput("reset_miss_count", 32'(miss_count), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Read hit on way 1
    exp_q.push_back(ev(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 0, 1, 0, 0));
    step();
    checkOutput("hit_count_1", 32'(hit_count), 32'd1);

    // Write hit on way 0
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
    exp_q.push_back(ev(1, 2'b01, 2'b00, 2'b00, 2'b01, 1, 1, 1, 0, 0, 0, 0, 0));
    step();

    // Read and write together behave as a write, here on way 1
    applyStimulus(1'b1, 1'b1, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0);
    exp_q.push_back(ev(1, 2'b10, 2'b00, 2'b00, 2'b10, 1, 1, 0, 0, 0, 1, 0, 0));
    step();

    // Both ways reporting a hit: way 0 takes priority
    applyStimulus(1'b1, 1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0);
    exp_q.push_back(ev(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0));
    step();
    checkOutput("hit_count_4", 32'(hit_count), 32'd4);

    // Clean miss: way 1 invalid, so it is the victim and no writeback is needed
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    step();
    checkOutput("clean_miss_count", 32'(miss_count), 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("fill_pmem_rd_wr_asel", 32'({pmem_read, pmem_write, addr_sel}), 32'b100);
      if (i < 4) step();
    end
    pmem_resp = 1'b1;
    exp_q.push_back(ev(0, 2'b10, 2'b10, 2'b10, 2'b10, 0, 0, 0, 1, 0, 0, 1, 0));
    step();
    applyStimulus(1'b1, 1'b0, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0);
    exp_q.push_back(ev(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 0, 1, 0, 0));
    step();
    checkOutput("after_fill_hit_count", 32'(hit_count), 32'd5);
    checkOutput("after_fill_miss_count", 32'(miss_count), 32'd1);

    // Dirty miss: both valid, LRU way 0 is dirty, so write it back first
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b11, 2'b01, 1'b0, 1'b0);
    step();
    checkOutput("wb_pmem_wr_rd_asel_way", 32'({pmem_write, pmem_read, addr_sel, way_sel}), 32'b1010);
    step();
    checkOutput("wb_held", 32'({pmem_write, pmem_read}), 32'b10);
    pmem_resp = 1'b1;
    step();
    checkOutput("fill_after_wb", 32'({pmem_read, pmem_write, addr_sel}), 32'b100);
    // Request dropped mid-fill; the response arrives on the FILL entry cycle
    mem_read = 1'b0;
    exp_q.push_back(ev(0, 2'b01, 2'b01, 2'b01, 2'b01, 0, 0, 0, 1, 0, 0, 1, 0));
    step();
    pmem_resp = 1'b0;
    checkOutput("dropped_no_resp", 32'(mem_resp), 32'd0);
    step();
    checkOutput("dropped_hit_count", 32'(hit_count), 32'd5);
    checkOutput("dropped_miss_count", 32'(miss_count), 32'd2);

    // pmem_resp with no request in IDLE has no effect
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    checkOutput("idle_presp_ignored", 32'({pmem_read, pmem_write}), 32'b00);

    // Dirty miss on way 1, then reset while filling
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b11, 2'b10, 1'b1, 1'b0);
    step();
    checkOutput("wb1_pmem_wr_asel_way", 32'({pmem_write, addr_sel, way_sel}), 32'b111);
    checkOutput("wb1_miss_count", 32'(miss_count), 32'd3);
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    checkOutput("fill1_pmem_rd", 32'(pmem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_pmem_rd", 32'(pmem_read), 32'd0);
    checkOutput("async_reset_hit_count", 32'(hit_count), 32'd0);
    checkOutput("async_reset_miss_count", 32'(miss_count), 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("post_reset_idle", 32'({pmem_read, pmem_write}), 32'b00);

    // Hit counter wrap
    applyStimulus(1'b1, 1'b0, 2'b01, 2'b11, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) begin
      exp_q.push_back(ev(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0));
      step();
    end
    checkOutput("hit_count_max", 32'(hit_count), 32'hFFFF);
    exp_q.push_back(ev(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0));
    step();
    checkOutput("hit_count_wrap", 32'(hit_count), 32'h0);
    checkOutput("wrap_miss_count", 32'(miss_count), 32'h0);

    applyStimulus(1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0);
    step();
    step();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
